// File: rtl/mem_access_unit_if.sv
// Pipeline request and word-memory bus for mem_access_unit.
// master: MEM stage plus data memory; slave: the unit itself.
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              stall;
  logic [31:0]       load_data;
  logic              misalign;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_wd;
  logic [31:0]       mem_rd;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    output mem_rd,
    input  stall, load_data, misalign,
    input  mem_we, mem_a, mem_wd
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  mem_rd,
    output stall, load_data, misalign,
    output mem_we, mem_a, mem_wd
  );
endinterface

// File: rtl/mem_access_unit.sv
// Big-endian load/store unit; sb/sh as read-modify-write.
// Option: MEM_ACCESS_MISALIGN_TRAP_EN enables misalign trapping.
module mem_access_unit #(
  parameter int ADDR_W = 32
) (
  input logic         clk,
  input logic         rst_n,
  mem_access_unit_if.slave bus
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] hold_a;
  logic [31:0]       hold_wd;

  logic [1:0]  off;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        wr_state;
  logic        mis;
  logic        rmw;
  logic        sw;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext;
  logic [31:0] merged;

  assign off      = bus.req_addr[1:0];
  assign is_byte  = (bus.req_size == 2'b00);
  assign is_half  = (bus.req_size == 2'b01);
  assign is_word  = bus.req_size[1];
  assign wr_state = (state == WRITE);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign mis = bus.req_valid & ~wr_state &
               ((is_half & off[0]) |
                (is_word & (off != 2'b00)));
`else
  assign mis = 1'b0;
`endif

  assign rmw = bus.req_valid & bus.req_we &
               ~is_word & ~mis;
  assign sw  = bus.req_valid & bus.req_we &
               is_word & ~mis;

  always_comb begin
    byte_sel = 8'h00;
    case (off)
      2'd0: byte_sel = bus.mem_rd[31:24];
      2'd1: byte_sel = bus.mem_rd[23:16];
      2'd2: byte_sel = bus.mem_rd[15:8];
      2'd3: byte_sel = bus.mem_rd[7:0];
      default: byte_sel = 8'h00;
    endcase
    half_sel = off[1] ? bus.mem_rd[15:0]
                      : bus.mem_rd[31:16];
  end

  always_comb begin
    ext    = bus.mem_rd;
    merged = bus.mem_rd;
    unique case (1'b1)
      is_byte: begin
        ext = {{24{~bus.req_unsigned & byte_sel[7]}},
               byte_sel};
        case (off)
          2'd0: merged[31:24] = bus.req_wdata[7:0];
          2'd1: merged[23:16] = bus.req_wdata[7:0];
          2'd2: merged[15:8]  = bus.req_wdata[7:0];
          2'd3: merged[7:0]   = bus.req_wdata[7:0];
          default: merged = bus.mem_rd;
        endcase
      end
      is_half: begin
        ext = {{16{~bus.req_unsigned & half_sel[15]}},
               half_sel};
        if (off[1])
          merged[15:0] = bus.req_wdata[15:0];
        else
          merged[31:16] = bus.req_wdata[15:0];
      end
      is_word: begin
        ext    = bus.mem_rd;
        merged = bus.req_wdata;
      end
    endcase
  end

  assign bus.misalign  = mis;
  assign bus.load_data = mis ? 32'h0 : ext;
  assign bus.mem_a     = wr_state ? hold_a : bus.req_addr;
  assign bus.mem_wd    = wr_state ? hold_wd : bus.req_wdata;
  // Reset gating keeps the memory and pipeline quiet while held.
  assign bus.mem_we    = rst_n & (wr_state | sw);
  assign bus.stall     = rst_n & ~wr_state & rmw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hold_a  <= '0;
      hold_wd <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rmw) begin
            hold_a  <= bus.req_addr;
            hold_wd <= merged;
            state   <= WRITE;
          end
        end
        WRITE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the MEM stage of the pipelined MIPS core and the word-only data memory port (`we`, `a`, `wd`, `rd`; combinational word read, word write on clock edge). It performs byte/halfword lane extraction and extension for loads. It implements `sb`/`sh` as a two-cycle read-modify-write, stalling the pipeline for one cycle. Word loads and stores pass through with zero added latency.

## Interface
- `ADDR_W`, default 32: request and memory address width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  MEM stage holds a memory operation.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  size code: 00 byte, 01 half, 10 word; 11 is treated as word.
- `req_unsigned`  in  1  load zero-extends (`lbu`/`lhu`); ignored for stores.
- `req_addr`  in  ADDR_W  byte address.
- `req_wdata`  in  32  store data; the byte or half is taken from the low bits.
- `stall`  out  1  hold the MEM stage and everything upstream.
- `load_data`  out  32  extended load result.
- `misalign`  out  1  misaligned access flag; see Configuration.
- `mem_we`  out  1  memory write enable.
- `mem_a`  out  ADDR_W  memory byte address; memory uses bits [31:2].
- `mem_wd`  out  32  memory write data.
- `mem_rd`  in  32  memory read data, combinational from `mem_a`.

## Operation
- Byte lanes are big-endian:
  - byte offset 0 maps to bits [31:24], offset 3 to bits [7:0].
  - half offset 0 maps to bits [31:16].
- FSM states: IDLE and WRITE. Registered state:
  - `hold_a`: word address.
  - `hold_wd`: merged word.
- IDLE, no request or a load:
  - `mem_a` = `req_addr`, `mem_we` = 0, `stall` = 0.
  - `load_data` is the selected lane of `mem_rd`, sign- or zero-extended per `req_unsigned`.
  - A word load passes `mem_rd` through unchanged.
- IDLE with `sw`:
  - `mem_we` = 1, `mem_wd` = `req_wdata`, `stall` = 0.
  - Completes in the same cycle.
- IDLE with `sb`/`sh` (read phase):
  - `mem_a` = `req_addr`, `mem_we` = 0, `stall` = 1.
  - At the clock edge: `hold_wd` = `mem_rd` with the addressed lane replaced by `req_wdata[7:0]` or `[15:0]`; `hold_a` = `req_addr`; go to WRITE.
- WRITE:
  - `mem_a` = `hold_a`, `mem_wd` = `hold_wd`, `mem_we` = 1, `stall` = 0.
  - Return to IDLE at the next edge unconditionally.
  - Request inputs are ignored in this state. The pipeline holds the same request while stalled, and it retires this cycle.
- `load_data` outside a load is don't-care, but it is driven deterministically from the lane logic.

## Timing
- Reset values: state = IDLE, `hold_a` = 0, `hold_wd` = 0.
- While `rst_n` is low, `mem_we` = 0 and `stall` = 0 regardless of inputs.
- Latency:
  - Loads and `sw`: 0 extra cycles.
  - `sb`/`sh`: exactly 1 stall cycle; the memory write occurs at the end of the second cycle.
- Reset asserted in WRITE: the write is abandoned, memory is unchanged, and the FSM is in IDLE on release.
- Back-to-back `sb` requests: each takes 2 cycles, and no write is ever skipped. The second read phase observes the first write, because the memory updated at the preceding edge.
- `req_valid` low in WRITE does not cancel the write.

## Configuration
- Macro: `MEM_ACCESS_MISALIGN_TRAP_EN`.
- Defined:
  - `misalign` = `req_valid` & ((half & `addr[0]`) | (word & `addr[1:0]` ≠ 0)), combinational, only in IDLE.
  - A misaligned store issues no `mem_we` and does not enter WRITE.
  - A misaligned load returns `load_data` = 0.
  - `stall` = 0 for any misaligned request.
- Undefined:
  - `misalign` is tied to 0.
  - Alignment bits are ignored: a half access uses only `addr[1]`; a word access ignores `addr[1:0]`.

## Test plan
- Loads, with word 0x8822_3344 at 0x10:
  - `lb` 0x10 → 0xFFFF_FF88.
  - `lbu` 0x10 → 0x0000_0088.
  - `lh` 0x12 → 0x0000_3344.
  - `lb` 0x13 → 0x0000_0044.
  - `stall` stays 0 throughout.
- `sw` 0x20 with data 0xDEAD_BEEF → `mem_we` = 1 in the same cycle, `stall` = 0, word 0x20 reads 0xDEAD_BEEF.
- `sb` 0x13 with data 0x0000_00AA, word 0x1122_3344:
  - Cycle N: `stall` = 1, `mem_we` = 0.
  - Cycle N+1: `mem_we` = 1, `mem_wd` = 0x1122_33AA, `stall` = 0.
  - `sh` 0x10 with data 0xBEEF on the same word → 0xBEEF_3344.
- Back-to-back `sb` 0x10 (0x11) then `sb` 0x11 (0x22) on word 0 → final 0x1122_0000, 4 cycles, 2 writes.
- Reset during WRITE of an `sb`: `mem_we` never pulses, the word is unchanged, and `stall` = 0 after release.
- `lw` 0x22:
  - With the macro: `misalign` = 1, `load_data` = 0.
  - Without the macro: returns the word at 0x20.
  - `sh` 0x11 with the macro: no write occurs.
